// File: rtl/instruction_fetch_register.sv
// ---------------------------------------------------------------------------
// instruction_fetch_register
//
// Fetches 32-bit MIPS instruction words over an Avalon-style read bus and
// registers each word. The word and its address are held with a valid/ready
// handshake until the consumer accepts it, and is split into decode fields.
// The consumer names the next fetch address on acceptance: either the
// sequential address (held pc + 4) or a redirect target (pc_load/pc_in). A
// next-fetch address equal to HALT_ADDRESS parks the fetcher until reset.
//
// Build option:
//   INSTR_BYTESWAP_EN  when defined, the captured bus word is byte-reversed.
//                      This suits a little-endian bus carrying a big-endian
//                      instruction image. When undefined, the word is captured
//                      unchanged. Timing is identical in both builds.
//
// Ports:
//   clk              single clock, all state changes on its rising edge
//   reset            synchronous, active-high reset
//   active           high while the fetcher is not halted
//   avm_address      fetch address (low two bits passed through unchecked)
//   avm_read         read request, held together with the address while stalled
//   avm_byteenable   always 4'b1111
//   avm_waitrequest  bus stall
//   avm_readdata     read data, taken when avm_read=1 and avm_waitrequest=0
//   instr_valid      the held instruction is valid
//   instr_ready      the consumer accepts the held instruction this cycle
//   pc_load          on acceptance, fetch next from pc_in instead of pc_out+4
//   pc_in            redirect target
//   pc_out           address of the held instruction
//   instr_word       held instruction
//   opcode/rs/rt/rd/shamt/funct/itype_immediate/jtype_target
//                    decode fields, pure slices of instr_word
//
// States:
//   state  | meaning
//   FETCH  | read in progress at fetch_pc, waiting for the bus to return data
//   VALID  | instruction held, waiting for the consumer to accept it
//   HALTED | next-fetch address hit HALT_ADDRESS, idle until reset
// ---------------------------------------------------------------------------
module instruction_fetch_register #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_word,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] itype_immediate,
  output logic [25:0] jtype_target
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] pc_redirect;
  logic [31:0] fetched_word;
  logic        capture;

`ifdef INSTR_BYTESWAP_EN
  assign fetched_word = {avm_readdata[7:0], avm_readdata[15:8],
                         avm_readdata[23:16], avm_readdata[31:24]};
`else
  assign fetched_word = avm_readdata;
`endif

  assign pc_redirect = pc_load ? pc_in : fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      fetch_pc   <= RESET_VECTOR;
      instr_word <= 32'h0;
      pc_out     <= 32'h0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (capture) begin
        instr_word <= fetched_word;
        pc_out     <= fetch_pc;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    capture      = 1'b0;
    avm_read     = 1'b0;
    instr_valid  = 1'b0;
    active       = 1'b1;
    unique case (state)
      FETCH: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          capture      = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        // pc_load/pc_in only matter on acceptance.
        if (instr_ready) begin
          fetch_pc_nxt = pc_redirect;
          state_nxt    = (pc_redirect == HALT_ADDRESS) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        active = 1'b0;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign avm_address    = fetch_pc;
  assign avm_byteenable = 4'b1111;

  assign opcode          = instr_word[31:26];
  assign rs              = instr_word[25:21];
  assign rt              = instr_word[20:16];
  assign rd              = instr_word[15:11];
  assign shamt           = instr_word[10:6];
  assign funct           = instr_word[5:0];
  assign itype_immediate = instr_word[15:0];
  assign jtype_target    = instr_word[25:0];

endmodule
